// File: rtl/regfile_write_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_write_ctrl
//
// Owns the single write port (WE/A3/WD3) of the register file.
//   * After reset, or on an init_req pulse while arbitrating, it sweeps every
//     register with zero, one register per clock, starting at address 0.
//   * Once the sweep is done it arbitrates between two writers:
//       A - main writeback, normally has priority.
//       B - secondary unit; wins once after MAX_WAIT consecutive lost cycles.
//   * A write to address 0 completes its handshake but is dropped, so the
//     $zero register keeps its value.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst        in   asynchronous, active-high reset
//   init_req   in   restart the zero-fill sweep (honoured only in ARB)
//   a_valid    in   writer A has a write
//   a_addr     in   writer A destination register
//   a_data     in   writer A data
//   a_ready    out  A transfer accepted this cycle
//   b_valid    in   writer B has a write
//   b_addr     in   writer B destination register
//   b_data     in   writer B data
//   b_ready    out  B transfer accepted this cycle
//   rf_we      out  register file write enable (registered)
//   rf_a3      out  register file write address (registered)
//   rf_wd3     out  register file write data (registered)
//   init_done  out  high once the sweep has finished, low during a sweep
// ---------------------------------------------------------------------------
module regfile_write_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,  // must equal 2**ADDR_W
    parameter int MAX_WAIT = 4    // 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    output logic              init_done
);

    typedef enum logic {
        ST_INIT,
        ST_ARB
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        WAIT_LIMIT = 4'(MAX_WAIT);

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_wait_cnt;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_a3;
    logic [DATA_W-1:0] r_rf_wd3;
    logic              r_init_done;

    logic              w_arb_open;
    logic              w_b_starved;
    logic              w_b_grant;
    logic              w_a_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    // Grants are combinational so a requester can transfer every cycle with
    // no bubble; they depend only on state, wait count, valids and init_req,
    // never on data. A pending init_req blocks both writers for that cycle.
    assign w_arb_open  = (r_state == ST_ARB) && !init_req;
    assign w_b_starved = (r_wait_cnt == WAIT_LIMIT);
    assign w_b_grant   = w_arb_open && b_valid && (!a_valid || w_b_starved);
    assign w_a_grant   = w_arb_open && a_valid && !w_b_grant;

    // Exactly one grant can be high, so a single mux selects the winner.
    assign w_sel_addr  = w_b_grant ? b_addr : a_addr;
    assign w_sel_data  = w_b_grant ? b_data : a_data;

    // NOTE: every register in this block uses non-blocking assignment so that
    // all right-hand sides read the pre-edge values, matching real flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_rf_we     <= 1'b0;
            r_rf_a3     <= '0;
            r_rf_wd3    <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // Zero-fill sweep: one register per edge, $zero included.
                    r_rf_we    <= 1'b1;
                    r_rf_a3    <= r_idx;
                    r_rf_wd3   <= '0;
                    r_wait_cnt <= '0;
                    if (r_idx == LAST_IDX) begin
                        r_state     <= ST_ARB;
                        r_init_done <= 1'b1;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end

                ST_ARB: begin
                    if (init_req) begin
                        r_state     <= ST_INIT;
                        r_init_done <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_rf_we     <= 1'b0;
                    end else begin
                        if (w_a_grant || w_b_grant) begin
                            // Address 0 completes the handshake but the write
                            // is dropped; A3/WD3 keep their previous values.
                            r_rf_we <= (w_sel_addr != '0);
                            if (w_sel_addr != '0) begin
                                r_rf_a3  <= w_sel_addr;
                                r_rf_wd3 <= w_sel_data;
                            end
                        end else begin
                            r_rf_we <= 1'b0;
                        end

                        // Count consecutive cycles B waited while valid; the
                        // count saturates and clears once B wins or withdraws.
                        if (b_valid && !w_b_grant) begin
                            if (!w_b_starved) begin
                                r_wait_cnt <= r_wait_cnt + 4'd1;
                            end
                        end else begin
                            r_wait_cnt <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign a_ready   = w_a_grant;
    assign b_ready   = w_b_grant;
    assign rf_we     = r_rf_we;
    assign rf_a3     = r_rf_a3;
    assign rf_wd3    = r_rf_wd3;
    assign init_done = r_init_done;

endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Owns the single write port (WE/A3/WD3) of the 32x32 register file.
- Runs a zero-fill sweep of every register after reset or on request.
- Then arbitrates between two writers: A (main writeback, priority) and B (secondary unit, e.g. mult/div or load return), using valid/ready handshakes, anti-starvation for B, and hard suppression of writes to $zero.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, registers swept during init; must equal 2**ADDR_W.
- MAX_WAIT, 4, consecutive lost cycles after which B wins over A; range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_req  in  1  pulse: restart zero-fill sweep (honoured only in ARB).
- a_valid  in  1  writer A has a write.
- a_addr  in  ADDR_W  writer A destination.
- a_data  in  DATA_W  writer A data.
- a_ready  out  1  A transfer accepted this cycle.
- b_valid  in  1  writer B has a write.
- b_addr  in  ADDR_W  writer B destination.
- b_data  in  DATA_W  writer B data.
- b_ready  out  1  B transfer accepted this cycle.
- rf_we  out  1  to register file WE.
- rf_a3  out  ADDR_W  to register file A3.
- rf_wd3  out  DATA_W  to register file WD3.
- init_done  out  1  high once sweep finished; low during sweep.

Behaviour:
- Reset: one clock, asynchronous active-high reset `rst`.
  - While rst is high: state=INIT, idx=0, wait_cnt=0.
  - Outputs: rf_we=0, rf_a3=0, rf_wd3=0, init_done=0, a_ready=0, b_ready=0.
  - Reset mid-sweep or mid-transfer: all progress is discarded and the sweep restarts.
- rf_we/rf_a3/rf_wd3 are registered. A transfer accepted at edge N drives the port during cycle N..N+1, and the register file captures it at edge N+1. Fixed latency: one cycle.
- Handshake: a transfer occurs at a rising edge when valid and ready are both high.
  - Ready is combinational from state, wait_cnt, valid inputs and init_req.
  - Ready never depends on data.
  - Requesters hold addr/data stable while valid is high and not ready.
- States: INIT and ARB.
- INIT:
  - a_ready=b_ready=0.
  - Each edge registers rf_we=1, rf_a3=idx, rf_wd3=0, then idx++.
  - At the edge issuing idx=NUM_REGS-1: state moves to ARB, init_done goes to 1, idx goes to 0.
  - Exactly NUM_REGS write cycles; register 0 is also written (with zero).
- ARB, when init_req=1:
  - a_ready=b_ready=0, no transfer.
  - Next edge: state=INIT, init_done=0, wait_cnt=0, rf_we=0.
- ARB grant rule:
  - B is granted if b_valid and (!a_valid or wait_cnt==MAX_WAIT).
  - Otherwise A is granted if a_valid.
  - Only the granted requester sees ready=1; at most one ready is high per cycle.
- wait_cnt update each edge:
  - Increments, saturating at MAX_WAIT, when b_valid and B is not granted.
  - Clears when B transfers or b_valid=0.
- Accepted transfer with addr==0: handshake completes, but rf_we is registered 0 (write dropped, $zero stays 0).
- Accepted transfer with addr!=0: rf_we=1, rf_a3=addr, rf_wd3=data.
- No transfer: rf_we=0; rf_a3/rf_wd3 hold their previous values.
- Both valid with wait_cnt<MAX_WAIT: A wins and B waits. After MAX_WAIT lost cycles B wins once, then wait_cnt=0.
- Back-to-back transfers from one requester are sustained at one per cycle; there are no bubbles in ARB.

Test Plan:
- Sweep: release rst; valids high throughout.
  - Required: rf_we=1 for exactly 32 cycles with rf_a3=0,1,...,31 and rf_wd3=0; no ready asserted during them.
  - Required: init_done rises at the edge issuing addr 31; the regfile reads 0 on all addresses afterwards.
- Single write: in ARB, a_valid=1, a_addr=5, a_data=32'hDEADBEEF for one cycle.
  - Required: a_ready=1 that cycle; next cycle rf_we=1, rf_a3=5, rf_wd3=DEADBEEF.
  - Required: following cycle rf_we=0 and RD(5)=DEADBEEF.
- Starvation, MAX_WAIT=4: a_valid and b_valid held high, a_addr=1, b_addr=2, b_data=7.
  - Required grants: A,A,A,A,B,A,A,A,A,B,...
  - Required: b_ready pulses once every 5 cycles.
- $zero: b_valid=1, b_addr=0, b_data=32'hFFFFFFFF with a_valid=0.
  - Required: b_ready=1, rf_we stays 0, RD(0)=0.
- init_req mid-traffic: a_valid held high with init_req pulsed for one cycle in ARB.
  - Required: a_ready=0 that cycle; init_done falls; a fresh 32-cycle sweep runs; A is then accepted.
- Async reset mid-sweep: assert rst between clock edges at idx=10.
  - Required: rf_we=0 and init_done=0 immediately, without waiting for an edge.
  - Required: after release the sweep restarts from address 0.
